ibex_rvfi_retire_buffer: RTL and testbench



---
 rtl/ibex_rvfi_retire_buffer_if.sv | 80 ++++++++
 rtl/ibex_rvfi_retire_buffer.sv | 150 +++++++++++++++
 tb/tb_ibex_rvfi_retire_buffer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_rvfi_retire_buffer_if.sv
// Retire-side, late-writeback and RVFI beat signals of the retire buffer.
// The master drives retirements and writebacks; the slave emits RVFI beats.
interface ibex_rvfi_retire_buffer_if #(
    parameter int ORDER_W = 64
);
    logic               ret_valid_i;
    logic [31:0]        ret_pc_i;
    logic [31:0]        ret_pc_next_i;
    logic [31:0]        ret_insn_i;
    logic               ret_trap_i;
    logic               ret_intr_i;
    logic [4:0]         ret_rs1_addr_i;
    logic [4:0]         ret_rs2_addr_i;
    logic [31:0]        ret_rs1_rdata_i;
    logic [31:0]        ret_rs2_rdata_i;
    logic [4:0]         ret_rd_addr_i;
    logic [31:0]        ret_rd_wdata_i;
    logic [31:0]        ret_mem_addr_i;
    logic [31:0]        ret_mem_wdata_i;
    logic [3:0]         ret_mem_rmask_i;
    logic [3:0]         ret_mem_wmask_i;
    logic               ret_wb_pending_i;
    logic               wb_valid_i;
    logic [31:0]        wb_mem_rdata_i;
    logic [31:0]        wb_rd_wdata_i;
    logic               rvfi_valid;
    logic [ORDER_W-1:0] rvfi_order;
    logic [31:0]        rvfi_insn;
    logic               rvfi_trap;
    logic               rvfi_intr;
    logic [4:0]         rvfi_rs1_addr;
    logic [4:0]         rvfi_rs2_addr;
    logic [31:0]        rvfi_rs1_rdata;
    logic [31:0]        rvfi_rs2_rdata;
    logic [4:0]         rvfi_rd_addr;
    logic [31:0]        rvfi_rd_wdata;
    logic [31:0]        rvfi_pc_rdata;
    logic [31:0]        rvfi_pc_wdata;
    logic [31:0]        rvfi_mem_addr;
    logic [3:0]         rvfi_mem_rmask;
    logic [3:0]         rvfi_mem_wmask;
    logic [31:0]        rvfi_mem_rdata;
    logic [31:0]        rvfi_mem_wdata;

    modport master (
        output ret_valid_i, ret_pc_i, ret_pc_next_i, ret_insn_i,
        output ret_trap_i, ret_intr_i,
        output ret_rs1_addr_i, ret_rs2_addr_i,
        output ret_rs1_rdata_i, ret_rs2_rdata_i,
        output ret_rd_addr_i, ret_rd_wdata_i,
        output ret_mem_addr_i, ret_mem_wdata_i,
        output ret_mem_rmask_i, ret_mem_wmask_i, ret_wb_pending_i,
        output wb_valid_i, wb_mem_rdata_i, wb_rd_wdata_i,
        input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_intr,
        input  rvfi_rs1_addr, rvfi_rs2_addr,
        input  rvfi_rs1_rdata, rvfi_rs2_rdata,
        input  rvfi_rd_addr, rvfi_rd_wdata,
        input  rvfi_pc_rdata, rvfi_pc_wdata,
        input  rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
        input  rvfi_mem_rdata, rvfi_mem_wdata
    );

    modport slave (
        input  ret_valid_i, ret_pc_i, ret_pc_next_i, ret_insn_i,
        input  ret_trap_i, ret_intr_i,
        input  ret_rs1_addr_i, ret_rs2_addr_i,
        input  ret_rs1_rdata_i, ret_rs2_rdata_i,
        input  ret_rd_addr_i, ret_rd_wdata_i,
        input  ret_mem_addr_i, ret_mem_wdata_i,
        input  ret_mem_rmask_i, ret_mem_wmask_i, ret_wb_pending_i,
        input  wb_valid_i, wb_mem_rdata_i, wb_rd_wdata_i,
        output rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_intr,
        output rvfi_rs1_addr, rvfi_rs2_addr,
        output rvfi_rs1_rdata, rvfi_rs2_rdata,
        output rvfi_rd_addr, rvfi_rd_wdata,
        output rvfi_pc_rdata, rvfi_pc_wdata,
        output rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
        output rvfi_mem_rdata, rvfi_mem_wdata
    );
endinterface

// File: rtl/ibex_rvfi_retire_buffer.sv
// In-order retire buffer feeding RVFI: holds loads until their late
// writeback lands and emits one registered beat per cycle in program order.
module ibex_rvfi_retire_buffer #(
    parameter int DEPTH   = 4,
    parameter int ORDER_W = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    ibex_rvfi_retire_buffer_if.slave   bus,
    output logic                       overflow_o,
    output logic                       wb_err_o,
    output logic                       empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [31:0] insn;
        logic        trap;
        logic        intr;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
    } rec_t;

    rec_t               mem_q [DEPTH];
    rec_t               out_q;
    rec_t               ret_rec;
    logic [DEPTH-1:0]   pend_q, pend_d;
    logic [PW-1:0]      wr_q, rd_q;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [ORDER_W-1:0] ord_q, ord_out_q;
    logic               vld_q, ovf_q, werr_q;
    logic               full, enq, deq;
    logic               wb_hit, wb_take;
    logic [PW-1:0]      wb_idx;

    assign full    = (cnt_q == CW'(DEPTH));
    assign enq     = bus.ret_valid_i && !full;
    assign deq     = (cnt_q != '0) && !pend_q[rd_q];
    assign wb_take = bus.wb_valid_i && wb_hit;

    // Oldest held record still waiting for writeback, walking from the head.
    always_comb begin
        wb_hit = 1'b0;
        wb_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!wb_hit && (CW'(i) < cnt_q) && pend_q[rd_q + PW'(i)]) begin
                wb_hit = 1'b1;
                wb_idx = rd_q + PW'(i);
            end
        end
    end

    always_comb begin
        pend_d = pend_q;
        if (wb_take) pend_d[wb_idx] = 1'b0;
        if (enq)     pend_d[wr_q]   = bus.ret_wb_pending_i;
        cnt_d = cnt_q + CW'(enq) - CW'(deq);
    end

    always_comb begin
        ret_rec           = '0;
        ret_rec.pc        = bus.ret_pc_i;
        ret_rec.pc_next   = bus.ret_pc_next_i;
        ret_rec.insn      = bus.ret_insn_i;
        ret_rec.trap      = bus.ret_trap_i;
        ret_rec.intr      = bus.ret_intr_i;
        ret_rec.rs1_addr  = bus.ret_rs1_addr_i;
        ret_rec.rs2_addr  = bus.ret_rs2_addr_i;
        ret_rec.rs1_rdata = bus.ret_rs1_rdata_i;
        ret_rec.rs2_rdata = bus.ret_rs2_rdata_i;
        ret_rec.rd_addr   = bus.ret_rd_addr_i;
        ret_rec.rd_wdata  = bus.ret_rd_wdata_i;
        ret_rec.mem_addr  = bus.ret_mem_addr_i;
        ret_rec.mem_wdata = bus.ret_mem_wdata_i;
        ret_rec.mem_rmask = bus.ret_mem_rmask_i;
        ret_rec.mem_wmask = bus.ret_mem_wmask_i;
    end

    // Payload storage needs no reset; validity lives in cnt_q/pend_q.
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wr_q] <= ret_rec;
        if (wb_take) begin
            mem_q[wb_idx].mem_rdata <= bus.wb_mem_rdata_i;
            mem_q[wb_idx].rd_wdata  <= bus.wb_rd_wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            pend_q    <= '0;
            ord_q     <= '0;
            ord_out_q <= '0;
            out_q     <= '0;
            vld_q     <= 1'b0;
            ovf_q     <= 1'b0;
            werr_q    <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            vld_q  <= deq;
            if (enq) wr_q <= wr_q + PW'(1);
            if (bus.ret_valid_i && full) ovf_q <= 1'b1;
            if (bus.wb_valid_i && !wb_hit) werr_q <= 1'b1;
            if (deq) begin
                rd_q      <= rd_q + PW'(1);
                out_q     <= mem_q[rd_q];
                ord_out_q <= ord_q;
                ord_q     <= ord_q + ORDER_W'(1);
            end
        end
    end

    assign overflow_o = ovf_q;
    assign wb_err_o   = werr_q;
    assign empty_o    = (cnt_q == '0);

    assign bus.rvfi_valid     = vld_q;
    assign bus.rvfi_order     = ord_out_q;
    assign bus.rvfi_insn      = out_q.insn;
    assign bus.rvfi_trap      = out_q.trap;
    assign bus.rvfi_intr      = out_q.intr;
    assign bus.rvfi_rs1_addr  = out_q.rs1_addr;
    assign bus.rvfi_rs2_addr  = out_q.rs2_addr;
    assign bus.rvfi_rs1_rdata = out_q.rs1_rdata;
    assign bus.rvfi_rs2_rdata = out_q.rs2_rdata;
    assign bus.rvfi_rd_addr   = out_q.rd_addr;
    assign bus.rvfi_rd_wdata  = out_q.rd_wdata;
    assign bus.rvfi_pc_rdata  = out_q.pc;
    assign bus.rvfi_pc_wdata  = out_q.pc_next;
    assign bus.rvfi_mem_addr  = out_q.mem_addr;
    assign bus.rvfi_mem_rmask = out_q.mem_rmask;
    assign bus.rvfi_mem_wmask = out_q.mem_wmask;
    assign bus.rvfi_mem_rdata = out_q.mem_rdata;
    assign bus.rvfi_mem_wdata = out_q.mem_wdata;
endmodule

// File: tb/tb_ibex_rvfi_retire_buffer.sv
// Bench for the RVFI retire buffer: directed scenarios plus random traffic
// checked cycle by cycle against a queue-based program-order model.
module tb_ibex_rvfi_retire_buffer;
    localparam int DEPTH = 4;
    localparam int OW    = 64;

    logic clk = 1'b0;
    logic rst;
    logic ovf, werr, empty;

    always #5 clk = ~clk;

    ibex_rvfi_retire_buffer_if #(.ORDER_W(OW)) bus ();

    ibex_rvfi_retire_buffer #(.DEPTH(DEPTH), .ORDER_W(OW)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus),
        .overflow_o (ovf),
        .wb_err_o   (werr),
        .empty_o    (empty)
    );

    typedef struct {
        logic [31:0] pc, pcn, insn;
        logic        trap, intr;
        logic [4:0]  rs1a, rs2a;
        logic [31:0] rs1d, rs2d;
        logic [4:0]  rda;
        logic [31:0] rdw, maddr, mrdata, mwdata;
        logic [3:0]  rmask, wmask;
        bit          pend;
    } rec_t;

    rec_t            q[$];
    rec_t            exp_r;
    bit              exp_v;
    longint unsigned ordc, exp_ord;
    bit              m_ovf, m_werr;
    int              total, passed, beats;

    function automatic logic [511:0] pk(rec_t r);
        return 512'({r.pc, r.pcn, r.insn, r.trap, r.intr, r.rs1a, r.rs2a,
                     r.rs1d, r.rs2d, r.rda, r.rdw, r.maddr, r.mrdata,
                     r.mwdata, r.rmask, r.wmask});
    endfunction

    function automatic rec_t obs();
        rec_t r;
        r.pc     = bus.rvfi_pc_rdata;
        r.pcn    = bus.rvfi_pc_wdata;
        r.insn   = bus.rvfi_insn;
        r.trap   = bus.rvfi_trap;
        r.intr   = bus.rvfi_intr;
        r.rs1a   = bus.rvfi_rs1_addr;
        r.rs2a   = bus.rvfi_rs2_addr;
        r.rs1d   = bus.rvfi_rs1_rdata;
        r.rs2d   = bus.rvfi_rs2_rdata;
        r.rda    = bus.rvfi_rd_addr;
        r.rdw    = bus.rvfi_rd_wdata;
        r.maddr  = bus.rvfi_mem_addr;
        r.mrdata = bus.rvfi_mem_rdata;
        r.mwdata = bus.rvfi_mem_wdata;
        r.rmask  = bus.rvfi_mem_rmask;
        r.wmask  = bus.rvfi_mem_wmask;
        r.pend   = 1'b0;
        return r;
    endfunction

    task automatic chk(string tag, logic [511:0] o, logic [511:0] e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    endtask

    task automatic set_ret(bit v, bit p, logic [31:0] pc);
        bus.ret_valid_i      = v;
        bus.ret_wb_pending_i = p;
        bus.ret_pc_i         = pc;
        bus.ret_pc_next_i    = pc + 32'd4;
        bus.ret_insn_i       = $urandom;
        bus.ret_trap_i       = 1'($urandom);
        bus.ret_intr_i       = 1'($urandom);
        bus.ret_rs1_addr_i   = 5'($urandom);
        bus.ret_rs2_addr_i   = 5'($urandom);
        bus.ret_rs1_rdata_i  = $urandom;
        bus.ret_rs2_rdata_i  = $urandom;
        bus.ret_rd_addr_i    = 5'($urandom);
        bus.ret_rd_wdata_i   = $urandom;
        bus.ret_mem_addr_i   = $urandom;
        bus.ret_mem_wdata_i  = $urandom;
        bus.ret_mem_rmask_i  = 4'($urandom);
        bus.ret_mem_wmask_i  = 4'($urandom);
    endtask

    task automatic set_wb(bit v, logic [31:0] md);
        bus.wb_valid_i     = v;
        bus.wb_mem_rdata_i = md;
        bus.wb_rd_wdata_i  = $urandom;
    endtask

    task automatic idle();
        set_ret(1'b0, 1'b0, 32'h0);
        set_wb(1'b0, 32'h0);
    endtask

    // Program-order model: all decisions use the state at start of cycle.
    task automatic model();
        int   n;
        bit   deq, found;
        rec_t r;
        n     = q.size();
        deq   = (n > 0) && !q[0].pend;
        exp_v = 1'b0;
        if (bus.wb_valid_i) begin
            found = 1'b0;
            for (int i = 0; i < n; i++) begin
                if (!found && q[i].pend) begin
                    q[i].mrdata = bus.wb_mem_rdata_i;
                    q[i].rdw    = bus.wb_rd_wdata_i;
                    q[i].pend   = 1'b0;
                    found       = 1'b1;
                end
            end
            if (!found) m_werr = 1'b1;
        end
        if (deq) begin
            exp_v   = 1'b1;
            exp_r   = q.pop_front();
            exp_ord = ordc;
            ordc++;
        end
        if (bus.ret_valid_i) begin
            if (n < DEPTH) begin
                r.pc     = bus.ret_pc_i;
                r.pcn    = bus.ret_pc_next_i;
                r.insn   = bus.ret_insn_i;
                r.trap   = bus.ret_trap_i;
                r.intr   = bus.ret_intr_i;
                r.rs1a   = bus.ret_rs1_addr_i;
                r.rs2a   = bus.ret_rs2_addr_i;
                r.rs1d   = bus.ret_rs1_rdata_i;
                r.rs2d   = bus.ret_rs2_rdata_i;
                r.rda    = bus.ret_rd_addr_i;
                r.rdw    = bus.ret_rd_wdata_i;
                r.maddr  = bus.ret_mem_addr_i;
                r.mrdata = 32'h0;
                r.mwdata = bus.ret_mem_wdata_i;
                r.rmask  = bus.ret_mem_rmask_i;
                r.wmask  = bus.ret_mem_wmask_i;
                r.pend   = bus.ret_wb_pending_i;
                q.push_back(r);
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic step(string tag);
        model();
        @(posedge clk);
        #1;
        if (bus.rvfi_valid === 1'b1) beats++;
        chk({tag, "_valid"}, 512'(bus.rvfi_valid), 512'(exp_v));
        if (exp_v) begin
            chk({tag, "_order"}, 512'(bus.rvfi_order), 512'(exp_ord));
            chk({tag, "_beat"}, pk(obs()), pk(exp_r));
        end
        chk({tag, "_empty"}, 512'(empty), 512'(q.size() == 0));
        chk({tag, "_ovf"}, 512'(ovf), 512'(m_ovf));
        chk({tag, "_werr"}, 512'(werr), 512'(m_werr));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        q.delete();
        ordc   = 0;
        m_ovf  = 1'b0;
        m_werr = 1'b0;
        exp_v  = 1'b0;
        chk("rst_valid", 512'(bus.rvfi_valid), 512'(0));
        chk("rst_order", 512'(bus.rvfi_order), 512'(0));
        chk("rst_fields", pk(obs()), 512'(0));
        chk("rst_empty", 512'(empty), 512'(1));
        chk("rst_ovf", 512'(ovf), 512'(0));
        chk("rst_werr", 512'(werr), 512'(0));
        rst = 1'b0;
    endtask

    initial begin
        int b0;
        logic [31:0] pc;
        total  = 0;
        passed = 0;
        beats  = 0;
        rst    = 1'b1;
        idle();
        do_reset();

        // Three back-to-back non-pending retires.
        b0 = beats;
        set_ret(1'b1, 1'b0, 32'h100); step("seq0");
        set_ret(1'b1, 1'b0, 32'h104); step("seq1");
        set_ret(1'b1, 1'b0, 32'h108); step("seq2");
        idle();
        repeat (4) step("seq_drain");
        chk("seq_beats", 512'(beats - b0), 512'(3));
        chk("seq_order_next", 512'(ordc), 512'(3));

        // Pending load blocks a younger ALU op until writeback.
        b0 = beats;
        set_ret(1'b1, 1'b1, 32'h200); step("ld0");
        set_ret(1'b1, 1'b0, 32'h204); step("ld1");
        idle();
        repeat (5) step("ld_wait");
        chk("ld_noearly", 512'(beats - b0), 512'(0));
        set_wb(1'b1, 32'hDEADBEEF); step("ld_wb");
        idle();
        repeat (4) step("ld_drain");
        chk("ld_beats", 512'(beats - b0), 512'(2));

        // Fill behind a pending head and overflow on the fifth retire.
        b0 = beats;
        set_ret(1'b1, 1'b1, 32'h300); step("ov0");
        for (int i = 1; i < 5; i++) begin
            set_ret(1'b1, 1'b0, 32'h300 + 32'(4 * i));
            step("ovn");
        end
        idle();
        step("ov_hold");
        chk("ov_sticky", 512'(ovf), 512'(1));
        set_wb(1'b1, 32'h12345678); step("ov_wb");
        idle();
        repeat (8) step("ov_drain");
        chk("ov_beats", 512'(beats - b0), 512'(4));

        // Writeback with nothing pending.
        b0 = beats;
        set_wb(1'b1, 32'h0BADF00D); step("we0");
        idle();
        repeat (3) step("we_idle");
        chk("we_nobeat", 512'(beats - b0), 512'(0));

        // Reset while two records are held.
        set_ret(1'b1, 1'b1, 32'h400); step("rh0");
        set_ret(1'b1, 1'b0, 32'h404); step("rh1");
        idle();
        step("rh2");
        do_reset();

        // Same-cycle pending retire and writeback: writeback misses it.
        b0 = beats;
        set_ret(1'b1, 1'b1, 32'h500);
        set_wb(1'b1, 32'h55555555);
        step("sc0");
        idle();
        repeat (3) step("sc_wait");
        chk("sc_nobeat", 512'(beats - b0), 512'(0));
        set_wb(1'b1, 32'hA5A5A5A5); step("sc_wb");
        idle();
        repeat (3) step("sc_drain");
        chk("sc_beats", 512'(beats - b0), 512'(1));

        // Random traffic.
        do_reset();
        pc = 32'h1000;
        repeat (400) begin
            set_ret(1'($urandom), ($urandom % 4) == 0, pc);
            set_wb(($urandom % 4) == 0, $urandom);
            step("rnd");
            pc = pc + 32'd4;
        end
        set_ret(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 40; i++) begin
            set_wb(q.size() != 0, $urandom);
            step("rnd_drain");
        end
        chk("rnd_empty", 512'(empty), 512'(1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
